// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select, with RAW hazard handling against EX/MEM and MEM/WB.
// Define ALU_FWD_EN to enable result bypassing; otherwise the stage self-stalls on a dependency.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]    in_rs1_data,
  input  logic [DATA_WIDTH-1:0]    in_rs2_data,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic [REG_ADDR_W-1:0]    in_rs1,
  input  logic [REG_ADDR_W-1:0]    in_rs2,
  input  logic [REG_ADDR_W-1:0]    in_rd,
  input  logic [OPCODE_LENGTH-1:0] in_alu_op,
  input  logic                     in_alu_src,
  input  logic                     in_a_pc,
  input  logic                     in_jalr,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     exmem_regwrite,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic                     memwb_regwrite,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     Jalr,
  output logic [REG_ADDR_W-1:0]    out_rd,
  output logic [DATA_WIDTH-1:0]    out_store_data,
  output logic                     raw_hazard
);

  typedef struct packed {
    logic                     valid;
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic [REG_ADDR_W-1:0]    rs1;
    logic [REG_ADDR_W-1:0]    rs2;
    logic [REG_ADDR_W-1:0]    rd;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic                     alu_src;
    logic                     a_pc;
    logic                     jalr;
  } stage_t;

  stage_t stage_q;
  stage_t stage_in;
  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  always_comb begin
    stage_in.valid    = in_valid;
    stage_in.pc       = in_pc;
    stage_in.rs1_data = in_rs1_data;
    stage_in.rs2_data = in_rs2_data;
    stage_in.imm      = in_imm;
    stage_in.rs1      = in_rs1;
    stage_in.rs2      = in_rs2;
    stage_in.rd       = in_rd;
    stage_in.alu_op   = in_alu_op;
    stage_in.alu_src  = in_alu_src;
    stage_in.a_pc     = in_a_pc;
    stage_in.jalr     = in_jalr;
  end

  // A flushed stage is an all-zero bubble, i.e. ADD x0,x0,0 with valid low.
  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else if (!(stall || raw_hazard)) begin
      stage_q <= stage_in;
    end
  end

`ifdef ALU_FWD_EN
  // EX/MEM is the younger result and wins over MEM/WB; x0 is never bypassed.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    fwd_a = stage_q.rs1_data;
    fwd_b = stage_q.rs2_data;
    if (stage_q.rs1 != '0) begin
      if (exmem_regwrite && exmem_rd == stage_q.rs1)      fwd_a = exmem_result;
      else if (memwb_regwrite && memwb_rd == stage_q.rs1) fwd_a = memwb_result;
    end
    if (stage_q.rs2 != '0) begin
      if (exmem_regwrite && exmem_rd == stage_q.rs2)      fwd_b = exmem_result;
      else if (memwb_regwrite && memwb_rd == stage_q.rs2) fwd_b = memwb_result;
    end
  end

  assign raw_hazard = 1'b0;
`else
  logic hit_rs1;
  logic hit_rs2;
  logic unused_results;

  assign fwd_a = stage_q.rs1_data;
  assign fwd_b = stage_q.rs2_data;

  assign hit_rs1 = (stage_q.rs1 != '0) &&
                   ((exmem_regwrite && exmem_rd == stage_q.rs1) ||
                    (memwb_regwrite && memwb_rd == stage_q.rs1));
  assign hit_rs2 = (stage_q.rs2 != '0) &&
                   ((exmem_regwrite && exmem_rd == stage_q.rs2) ||
                    (memwb_regwrite && memwb_rd == stage_q.rs2));

  // No store marker reaches this stage and rs2 always feeds out_store_data,
  // so rs2 counts as used regardless of alu_src; rs1 is unused only for pc-relative ops.
  assign raw_hazard = stage_q.valid && ((!stage_q.a_pc && hit_rs1) || hit_rs2);

  assign unused_results = ^{exmem_result, memwb_result};
`endif

  assign in_ready       = !stall && !raw_hazard;
  assign out_valid      = stage_q.valid && !raw_hazard;
  assign SrcA           = stage_q.a_pc    ? stage_q.pc  : fwd_a;
  assign SrcB           = stage_q.alu_src ? stage_q.imm : fwd_b;
  assign out_store_data = fwd_b;
  assign Operation      = stage_q.alu_op;
  assign Jalr           = stage_q.jalr;
  assign out_rd         = stage_q.rd;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed table, hazard/forwarding sequences and random stimulus.
// Honours ALU_FWD_EN the same way as the design so either build can be checked.
module tb_id_ex_operand_stage;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic [OW-1:0] in_alu_op;
  logic          in_alu_src, in_a_pc, in_jalr;
  logic          stall, flush;
  logic          exmem_regwrite, memwb_regwrite;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic          in_ready, out_valid, Jalr, raw_hazard;
  logic [DW-1:0] SrcA, SrcB, out_store_data;
  logic [OW-1:0] Operation;
  logic [AW-1:0] out_rd;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_op(in_alu_op),
    .in_alu_src(in_alu_src), .in_a_pc(in_a_pc), .in_jalr(in_jalr),
    .stall(stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .in_ready(in_ready), .out_valid(out_valid), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .Jalr(Jalr), .out_rd(out_rd),
    .out_store_data(out_store_data), .raw_hazard(raw_hazard)
  );

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc, rs1_data, rs2_data, imm;
    logic [AW-1:0] rs1, rs2, rd;
    logic [OW-1:0] alu_op;
    logic          alu_src, a_pc, jalr;
  } instr_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] src_a, src_b, store;
    logic [OW-1:0] op;
    logic          jalr;
    logic [AW-1:0] rd;
    logic          hazard;
    logic          ready;
  } obs_t;

  typedef struct packed {
    instr_t in;
    logic   stall;
    logic   flush;
    obs_t   exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t e);
    check({tag, ".out_valid"},  DW'(out_valid),      DW'(e.valid));
    check({tag, ".SrcA"},       SrcA,                e.src_a);
    check({tag, ".SrcB"},       SrcB,                e.src_b);
    check({tag, ".store_data"}, out_store_data,      e.store);
    check({tag, ".Operation"},  DW'(Operation),      DW'(e.op));
    check({tag, ".Jalr"},       DW'(Jalr),           DW'(e.jalr));
    check({tag, ".out_rd"},     DW'(out_rd),         DW'(e.rd));
    check({tag, ".raw_hazard"}, DW'(raw_hazard),     DW'(e.hazard));
    check({tag, ".in_ready"},   DW'(in_ready),       DW'(e.ready));
  endtask

  function automatic instr_t mk_instr(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] d1,
                                      input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                                      input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                                      input logic [AW-1:0] rd, input logic [OW-1:0] op,
                                      input logic src, input logic apc, input logic jr);
    instr_t i;
    i.valid = v; i.pc = pc; i.rs1_data = d1; i.rs2_data = d2; i.imm = imm;
    i.rs1 = r1; i.rs2 = r2; i.rd = rd; i.alu_op = op;
    i.alu_src = src; i.a_pc = apc; i.jalr = jr;
    return i;
  endfunction

  function automatic obs_t mk_obs(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [DW-1:0] st, input logic [OW-1:0] op, input logic jr,
                                  input logic [AW-1:0] rd, input logic hz, input logic rdy);
    obs_t o;
    o.valid = v; o.src_a = a; o.src_b = b; o.store = st; o.op = op;
    o.jalr = jr; o.rd = rd; o.hazard = hz; o.ready = rdy;
    return o;
  endfunction

  task automatic apply(input instr_t i);
    in_valid = i.valid; in_pc = i.pc; in_rs1_data = i.rs1_data; in_rs2_data = i.rs2_data;
    in_imm = i.imm; in_rs1 = i.rs1; in_rs2 = i.rs2; in_rd = i.rd; in_alu_op = i.alu_op;
    in_alu_src = i.alu_src; in_a_pc = i.a_pc; in_jalr = i.jalr;
  endtask

  task automatic wb_clear();
    exmem_regwrite = 0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 0; memwb_rd = '0; memwb_result = '0;
  endtask

  // Reference model: an instruction held in the stage plus the writeback buses give the ALU view.
  function automatic logic written_back(input logic [AW-1:0] r);
    return (r != 0) && ((exmem_regwrite && exmem_rd == r) || (memwb_regwrite && memwb_rd == r));
  endfunction

  function automatic logic [DW-1:0] operand(input logic [AW-1:0] r, input logic [DW-1:0] d);
`ifdef ALU_FWD_EN
    if (r == 0) return d;
    if (exmem_regwrite && exmem_rd == r) return exmem_result;
    if (memwb_regwrite && memwb_rd == r) return memwb_result;
`endif
    return d;
  endfunction

  function automatic obs_t expect_of(input instr_t s);
    obs_t o;
    logic hz;
`ifdef ALU_FWD_EN
    hz = 1'b0;
`else
    hz = s.valid && ((!s.a_pc && written_back(s.rs1)) || written_back(s.rs2));
`endif
    o.hazard = hz;
    o.valid  = s.valid && !hz;
    o.src_a  = s.a_pc ? s.pc : operand(s.rs1, s.rs1_data);
    o.src_b  = s.alu_src ? s.imm : operand(s.rs2, s.rs2_data);
    o.store  = operand(s.rs2, s.rs2_data);
    o.op     = s.alu_op;
    o.jalr   = s.jalr;
    o.rd     = s.rd;
    o.ready  = !stall && !hz;
    return o;
  endfunction

  function automatic instr_t rand_instr();
    return mk_instr(1'($urandom), $urandom, $urandom, $urandom, $urandom,
                    AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom),
                    OW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  vec_t   vecs[8];
  instr_t model, cur;
  obs_t   e;
  logic   prev_ready;

  initial begin
    vecs[0] = '{mk_instr(1, 'h100, 5, 9, 7, 1, 2, 4, 4'b0010, 1, 0, 0), 0, 0,
                mk_obs(1, 5, 7, 9, 4'b0010, 0, 4, 0, 1)};
    vecs[1] = '{mk_instr(1, 'h104, 'h11, 'h22, 'h33, 3, 5, 6, 4'b0000, 0, 1, 1), 0, 0,
                mk_obs(1, 'h104, 'h22, 'h22, 4'b0000, 1, 6, 0, 1)};
    vecs[2] = '{mk_instr(1, 'h108, 'h44, 'h55, 'h66, 7, 8, 9, 4'b0101, 1, 0, 0), 1, 0,
                mk_obs(1, 'h104, 'h22, 'h22, 4'b0000, 1, 6, 0, 0)};
    vecs[3] = '{mk_instr(0, 'h10c, 1, 2, 3, 4, 5, 6, 4'b0111, 0, 0, 1), 1, 0,
                mk_obs(1, 'h104, 'h22, 'h22, 4'b0000, 1, 6, 0, 0)};
    vecs[4] = '{mk_instr(1, 'h110, 'h77, 'h88, 'h99, 1, 2, 3, 4'b1000, 1, 1, 1), 1, 0,
                mk_obs(1, 'h104, 'h22, 'h22, 4'b0000, 1, 6, 0, 0)};
    vecs[5] = '{mk_instr(1, 'h114, 'h12, 'h34, 'h56, 1, 2, 3, 4'b1001, 1, 0, 1), 1, 1,
                mk_obs(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0)};
    vecs[6] = '{mk_instr(0, 'h200, 1, 2, 3, 0, 0, 10, 4'b0110, 0, 0, 0), 0, 0,
                mk_obs(0, 1, 2, 2, 4'b0110, 0, 10, 0, 1)};
    vecs[7] = '{mk_instr(1, 'h208, 'hdead, 'hbeef, 4, 0, 0, 31, 4'b1111, 1, 1, 1), 0, 0,
                mk_obs(1, 'h208, 4, 'hbeef, 4'b1111, 1, 31, 0, 1)};

    // Reset held two cycles with busy inputs.
    reset = 1; stall = 0; flush = 0; wb_clear();
    apply(vecs[0].in);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check_obs($sformatf("reset%0d", c), mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    reset = 0; #1;
    check_obs("reset_release", mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Directed table: capture, stall with changing inputs, flush-with-stall, bubbles.
    for (int v = 0; v < 8; v++) begin
      apply(vecs[v].in); stall = vecs[v].stall; flush = vecs[v].flush;
      @(posedge clk); #1;
      check_obs($sformatf("vec%0d", v), vecs[v].exp);
    end
    stall = 0; flush = 0;

`ifdef ALU_FWD_EN
    // EX/MEM bypass beats MEM/WB; x0 never bypassed; store data forwarded too.
    apply(mk_instr(1, 'h400, 'h55, 'h66, 'h9, 3, 3, 1, 4'b0000, 1, 0, 0));
    @(posedge clk); #1;
    exmem_regwrite = 1; exmem_rd = 3; exmem_result = 'hAA;
    memwb_regwrite = 1; memwb_rd = 3; memwb_result = 'hBB; #1;
    check("fwd_exmem.SrcA", SrcA, 'hAA);
    check("fwd_exmem.store", out_store_data, 'hAA);
    check("fwd_exmem.SrcB", SrcB, 'h9);
    exmem_regwrite = 0; #1;
    check("fwd_memwb.SrcA", SrcA, 'hBB);
    check("fwd_nohazard", DW'(raw_hazard), 0);
    exmem_regwrite = 1;
    apply(mk_instr(1, 'h404, 'h77, 'h88, 'h1, 0, 0, 2, 4'b0001, 0, 0, 0));
    @(posedge clk); #1;
    exmem_rd = 0; memwb_rd = 0; #1;
    check("fwd_x0.SrcA", SrcA, 'h77);
    check("fwd_x0.SrcB", SrcB, 'h88);
    wb_clear();
`else
    // Self-stall on an EX/MEM match on rs2 (register operand), released the same cycle it clears.
    apply(mk_instr(1, 'h300, 'h10, 'h20, 'h30, 0, 7, 8, 4'b0001, 0, 0, 0));
    @(posedge clk); #1;
    exmem_regwrite = 1; exmem_rd = 7; exmem_result = 'hAA; #1;
    check_obs("haz_rs2", mk_obs(0, 'h10, 'h20, 'h20, 4'b0001, 0, 8, 1, 0));
    repeat (2) @(posedge clk);
    #1;
    check_obs("haz_hold", mk_obs(0, 'h10, 'h20, 'h20, 4'b0001, 0, 8, 1, 0));
    exmem_regwrite = 0; #1;
    check_obs("haz_clear", mk_obs(1, 'h10, 'h20, 'h20, 4'b0001, 0, 8, 0, 1));
    // MEM/WB match on rs1 stalls; the same match is ignored when SrcA is the pc.
    apply(mk_instr(1, 'h304, 1, 2, 3, 5, 0, 9, 4'b0000, 1, 0, 0));
    @(posedge clk); #1;
    memwb_regwrite = 1; memwb_rd = 5; #1;
    check("haz_rs1.raw_hazard", DW'(raw_hazard), 1);
    check("haz_rs1.out_valid", DW'(out_valid), 0);
    memwb_regwrite = 0;
    apply(mk_instr(1, 'h308, 1, 2, 3, 5, 0, 9, 4'b0000, 1, 1, 0));
    @(posedge clk); #1;
    memwb_regwrite = 1; #1;
    check("haz_pc.raw_hazard", DW'(raw_hazard), 0);
    check("haz_pc.SrcA", SrcA, 'h308);
    memwb_rd = 0;
    apply(mk_instr(1, 'h30c, 4, 5, 6, 0, 0, 1, 4'b0000, 0, 0, 0));
    @(posedge clk); #1;
    check("haz_x0.raw_hazard", DW'(raw_hazard), 0);
    wb_clear();
`endif

    // Back-to-back: four instructions, one per cycle, in order.
    for (int k = 0; k < 4; k++) begin
      apply(mk_instr(1, DW'(k * 4), DW'(k + 100), DW'(k + 200), DW'(k + 300),
                     AW'(k + 1), AW'(k + 2), AW'(k + 10), OW'(k), 0, 0, 0));
      @(posedge clk); #1;
      check($sformatf("b2b%0d.out_valid", k), DW'(out_valid), 1);
      check($sformatf("b2b%0d.SrcA", k), SrcA, DW'(k + 100));
      check($sformatf("b2b%0d.out_rd", k), DW'(out_rd), DW'(k + 10));
    end

    // Randomized run against the reference model, with upstream honouring in_ready.
    reset = 1; apply('0); @(posedge clk); #1;
    reset = 0; model = '0; cur = '0; prev_ready = 1;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      exmem_regwrite = 1'($urandom); exmem_rd = AW'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = AW'($urandom_range(0, 3)); memwb_result = $urandom;
      if (prev_ready) cur = rand_instr();
      apply(cur);
      #1;
      e = expect_of(model);
      check_obs($sformatf("rand%0d", n), e);
      prev_ready = e.ready;
      if (reset || flush) model = '0;
      else if (e.ready)   model = cur;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
